// File: rtl/snoop_responder_if.sv
// snoop_responder_if: snoop request, snoop result and writeback handshakes.
// master = system-bus side, slave = snoop responder.
interface snoop_responder_if #(
  parameter int ADDR_W = 32
);
  logic              snp_valid;
  logic              snp_ready;
  logic [2:0]        snp_op;
  logic [ADDR_W-1:0] snp_addr;
  logic              rsp_valid;
  logic [1:0]        rsp_result;
  logic              rsp_ready;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_ready;

  modport master (
    output snp_valid, snp_op, snp_addr,
    output rsp_ready, wb_ready,
    input  snp_ready, rsp_valid, rsp_result,
    input  wb_valid, wb_addr
  );

  modport slave (
    input  snp_valid, snp_op, snp_addr,
    input  rsp_ready, wb_ready,
    output snp_ready, rsp_valid, rsp_result,
    output wb_valid, wb_addr
  );
endinterface

// File: rtl/snoop_responder.sv
// snoop_responder: MESI snoop lookup, HITM writeback, then downgrade/invalidate.
// Define SNOOP_STATS_EN to add saturating hit/hitm/nohit result counters.
module snoop_responder #(
  parameter int WAYS       = 8,
  parameter int SETS       = 16384,
  parameter int LINE_BYTES = 64,
  parameter int ADDR_W     = 32,
  localparam int OFF_W     = $clog2(LINE_BYTES),
  localparam int IDX_W     = $clog2(SETS),
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W,
  localparam int WAY_W     = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  snoop_responder_if.slave      bus,
  output logic                  tag_rd_en,
  output logic [IDX_W-1:0]      tag_rd_idx,
  input  logic [WAYS*TAG_W-1:0] tag_rd_tags,
  input  logic [WAYS*2-1:0]     tag_rd_mesi,
  output logic                  mesi_wr_en,
  output logic [IDX_W-1:0]      mesi_wr_idx,
  output logic [WAY_W-1:0]      mesi_wr_way,
  output logic [1:0]            mesi_wr_state,
  output logic                  err_multi_hit,
  output logic                  err_protocol
`ifdef SNOOP_STATS_EN
  ,
  output logic [31:0]           stat_hit,
  output logic [31:0]           stat_hitm,
  output logic [31:0]           stat_nohit
`endif
);

  localparam int LA_W = ADDR_W - OFF_W;

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INV   = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  localparam logic [1:0] RES_NOHIT = 2'd0;
  localparam logic [1:0] RES_HIT   = 2'd1;
  localparam logic [1:0] RES_HITM  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CMP,
    S_RSP,
    S_WB,
    S_UPD
  } state_e;

  state_e           state_q, state_d;
  logic [LA_W-1:0]  line_q, line_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       res_q, res_d;
  logic [1:0]       nst_q, nst_d;
  logic             chg_q, chg_d;
  logic [WAY_W-1:0] way_q, way_d;

  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;

  assign tag_q = line_q[LA_W-1 -: TAG_W];
  assign idx_q = line_q[IDX_W-1:0];

  logic [WAYS-1:0]  hit_vec;
  logic             found;
  logic [WAY_W-1:0] hit_way;
  logic [1:0]       hit_st;
  logic             multi;

  // Lowest-numbered matching way wins when the array is inconsistent.
  always_comb begin
    hit_vec = '0;
    found   = 1'b0;
    hit_way = '0;
    hit_st  = MESI_I;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = (tag_rd_tags[w*TAG_W +: TAG_W] == tag_q) &&
                   (tag_rd_mesi[w*2 +: 2] != MESI_I);
      if (hit_vec[w] && !found) begin
        found   = 1'b1;
        hit_way = WAY_W'(w);
        hit_st  = tag_rd_mesi[w*2 +: 2];
      end
    end
  end

  assign multi = |(hit_vec & (hit_vec - WAYS'(1)));

  logic [1:0] res_c;
  logic [1:0] nst_c;
  logic       chg_c;
  logic       perr_c;

  always_comb begin
    res_c  = RES_NOHIT;
    nst_c  = hit_st;
    chg_c  = 1'b0;
    perr_c = 1'b0;
    unique case (op_q)
      OP_READ: if (found) begin
        res_c = (hit_st == MESI_M) ? RES_HITM : RES_HIT;
        nst_c = MESI_S;
        chg_c = (hit_st != MESI_S);
      end
      OP_WRITE: ;
      OP_INV: if (found) begin
        nst_c  = MESI_I;
        chg_c  = 1'b1;
        perr_c = (hit_st == MESI_M) || (hit_st == MESI_E);
      end
      OP_RWIM: if (found) begin
        res_c = (hit_st == MESI_M) ? RES_HITM : RES_HIT;
        nst_c = MESI_I;
        chg_c = 1'b1;
      end
      default: perr_c = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    op_d    = op_q;
    res_d   = res_q;
    nst_d   = nst_q;
    chg_d   = chg_q;
    way_d   = way_q;
    unique case (state_q)
      S_IDLE: if (bus.snp_valid) begin
        line_d  = bus.snp_addr[ADDR_W-1:OFF_W];
        op_d    = bus.snp_op;
        state_d = S_RD;
      end
      S_RD: state_d = S_CMP;
      S_CMP: begin
        res_d   = res_c;
        nst_d   = nst_c;
        chg_d   = chg_c;
        way_d   = hit_way;
        state_d = S_RSP;
      end
      S_RSP: if (bus.rsp_ready) begin
        if (res_q == RES_HITM) state_d = S_WB;
        else if (chg_q)        state_d = S_UPD;
        else                   state_d = S_IDLE;
      end
      S_WB: if (bus.wb_ready) state_d = S_UPD;
      S_UPD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      op_q    <= '0;
      res_q   <= RES_NOHIT;
      nst_q   <= MESI_I;
      chg_q   <= 1'b0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      op_q    <= op_d;
      res_q   <= res_d;
      nst_q   <= nst_d;
      chg_q   <= chg_d;
      way_q   <= way_d;
    end
  end

  assign bus.snp_ready  = (state_q == S_IDLE);
  assign tag_rd_en      = (state_q == S_RD);
  assign tag_rd_idx     = tag_rd_en ? idx_q : '0;
  assign err_multi_hit  = (state_q == S_CMP) && multi;
  assign err_protocol   = (state_q == S_CMP) && perr_c;
  assign bus.rsp_valid  = (state_q == S_RSP);
  assign bus.rsp_result = bus.rsp_valid ? res_q : RES_NOHIT;
  assign bus.wb_valid   = (state_q == S_WB);
  assign bus.wb_addr    = bus.wb_valid ? {line_q, OFF_W'(0)} : '0;
  assign mesi_wr_en     = (state_q == S_UPD);
  assign mesi_wr_idx    = mesi_wr_en ? idx_q : '0;
  assign mesi_wr_way    = mesi_wr_en ? way_q : '0;
  assign mesi_wr_state  = mesi_wr_en ? nst_q : MESI_I;

`ifdef SNOOP_STATS_EN
  logic [31:0] hit_q, hitm_q, nohit_q;
  logic        rsp_hs;

  assign rsp_hs = (state_q == S_RSP) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q   <= '0;
      hitm_q  <= '0;
      nohit_q <= '0;
    end else if (rsp_hs) begin
      if (res_q == RES_HIT && hit_q != '1)     hit_q   <= hit_q + 32'd1;
      if (res_q == RES_HITM && hitm_q != '1)   hitm_q  <= hitm_q + 32'd1;
      if (res_q == RES_NOHIT && nohit_q != '1) nohit_q <= nohit_q + 32'd1;
    end
  end

  assign stat_hit   = hit_q;
  assign stat_hitm  = hitm_q;
  assign stat_nohit = nohit_q;
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder: directed and randomized snoops against a table-level
// MESI reference model; the bench also plays the tag/MESI array.
module tb_snoop_responder;
  localparam int WAYS   = 8;
  localparam int ADDR_W = 32;
  localparam int TAG_W  = 12;
  localparam int IDX_W  = 14;
  localparam int WAY_W  = 3;
  localparam int NS     = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snoop_responder_if #(.ADDR_W(ADDR_W)) bus();

  logic                  tag_rd_en;
  logic [IDX_W-1:0]      tag_rd_idx;
  logic [WAYS*TAG_W-1:0] tag_rd_tags;
  logic [WAYS*2-1:0]     tag_rd_mesi;
  logic                  mesi_wr_en;
  logic [IDX_W-1:0]      mesi_wr_idx;
  logic [WAY_W-1:0]      mesi_wr_way;
  logic [1:0]            mesi_wr_state;
  logic                  err_multi_hit;
  logic                  err_protocol;
`ifdef SNOOP_STATS_EN
  logic [31:0] stat_hit, stat_hitm, stat_nohit;
`endif

  snoop_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .tag_rd_en     (tag_rd_en),
    .tag_rd_idx    (tag_rd_idx),
    .tag_rd_tags   (tag_rd_tags),
    .tag_rd_mesi   (tag_rd_mesi),
    .mesi_wr_en    (mesi_wr_en),
    .mesi_wr_idx   (mesi_wr_idx),
    .mesi_wr_way   (mesi_wr_way),
    .mesi_wr_state (mesi_wr_state),
    .err_multi_hit (err_multi_hit),
    .err_protocol  (err_protocol)
`ifdef SNOOP_STATS_EN
    ,
    .stat_hit      (stat_hit),
    .stat_hitm     (stat_hitm),
    .stat_nohit    (stat_nohit)
`endif
  );

  logic [TAG_W-1:0] mtag [NS][WAYS];
  logic [1:0]       mst  [NS][WAYS];

  always @(posedge clk) begin
    if (tag_rd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_rd_tags[w*TAG_W +: TAG_W] <= mtag[tag_rd_idx[3:0]][w];
        tag_rd_mesi[w*2 +: 2]         <= mst[tag_rd_idx[3:0]][w];
      end
    end
  end

  int nchk = 0;
  int npass = 0;
  int exp_hit = 0, exp_hitm = 0, exp_nohit = 0;

  typedef struct {
    logic [1:0] res;
    logic [1:0] nst;
    bit         wr;
    bit         perr;
    bit         multi;
    int         way;
  } exp_t;

  // Spec-table model: result, new state and error flags from current state.
  function automatic exp_t predict(input logic [2:0] op, input logic [31:0] a);
    exp_t e;
    int idx = int'(a[9:6]);
    int nhit = 0;
    logic [1:0] st = 2'd0;
    e.way = -1;
    for (int w = 0; w < WAYS; w++)
      if (mtag[idx][w] == a[31:20] && mst[idx][w] != 2'd0) begin
        nhit++;
        if (e.way < 0) begin e.way = w; st = mst[idx][w]; end
      end
    e.res = 2'd0; e.nst = st; e.wr = 0; e.perr = 0; e.multi = (nhit > 1);
    case (op)
      3'd1: if (e.way >= 0) begin
        e.res = (st == 2'd3) ? 2'd2 : 2'd1; e.nst = 2'd1; e.wr = (st != 2'd1);
      end
      3'd2: ;
      3'd3: if (e.way >= 0) begin
        e.nst = 2'd0; e.wr = 1; e.perr = (st >= 2'd2);
      end
      3'd4: if (e.way >= 0) begin
        e.res = (st == 2'd3) ? 2'd2 : 2'd1; e.nst = 2'd0; e.wr = 1;
      end
      default: e.perr = 1;
    endcase
    return e;
  endfunction

  function automatic int exp_turn(input exp_t e, input int rs, input int ws);
    return 4 + rs + (e.wr ? 1 : 0) + ((e.res == 2'd2) ? 1 + ws : 0);
  endfunction

  int          o_turn, o_rd_cnt, o_rd_cyc, o_rsp_first, o_hs;
  int          o_wb_cnt, o_wr_cnt, o_multi, o_perr;
  logic [1:0]  o_res, o_wr_st;
  logic [2:0]  o_wr_way;
  logic [13:0] o_wr_idx, o_rd_idx;
  logic [31:0] o_wb_addr;
  bit          o_unstable, o_order_bad, o_acc_ready;
  logic        o_rst_wbv, o_rst_rdy, o_rst_rsp;

  task automatic clear_set(input int idx);
    for (int w = 0; w < WAYS; w++) begin mtag[idx][w] = '0; mst[idx][w] = 2'd0; end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input int rs, input int ws, input int rst_wb);
    int rc = 0, wc = 0;
    bit wbdone = 0;
    logic [1:0] rres = 2'd0;
    o_turn = 0; o_rd_cnt = 0; o_rd_cyc = 0; o_rsp_first = 0; o_hs = 0;
    o_wb_cnt = 0; o_wr_cnt = 0; o_multi = 0; o_perr = 0; o_res = 2'd3;
    o_wr_st = 2'd0; o_wr_way = '0; o_wr_idx = '0; o_rd_idx = '0;
    o_wb_addr = '0; o_unstable = 0; o_order_bad = 0;
    @(negedge clk);
    o_acc_ready = bus.snp_ready;
    bus.snp_valid = 1'b1; bus.snp_op = op; bus.snp_addr = a;
    bus.rsp_ready = (rs == 0); bus.wb_ready = (ws == 0);
    for (int s = 1; s <= 80; s++) begin
      @(negedge clk);
      bus.snp_valid = 1'b0;
      if (tag_rd_en) begin o_rd_cnt++; o_rd_cyc = s; o_rd_idx = tag_rd_idx; end
      if (err_multi_hit) o_multi++;
      if (err_protocol) o_perr++;
      if (bus.rsp_valid) begin
        if (rc == 0) begin o_rsp_first = s; rres = bus.rsp_result; end
        else if (bus.rsp_result !== rres) o_unstable = 1;
        rc++;
        bus.rsp_ready = (rc > rs);
        if (bus.rsp_ready) begin o_hs++; o_res = bus.rsp_result; end
      end
      if (bus.wb_valid) begin
        if (wc == 0) o_wb_addr = bus.wb_addr;
        else if (bus.wb_addr !== o_wb_addr) o_unstable = 1;
        wc++;
        bus.wb_ready = (wc > ws);
        if (bus.wb_ready) wbdone = 1;
        if (rst_wb > 0 && wc == rst_wb) begin
          rst_n = 1'b0;
          #1;
          o_rst_wbv = bus.wb_valid; o_rst_rdy = bus.snp_ready; o_rst_rsp = bus.rsp_valid;
          break;
        end
      end
      if (mesi_wr_en) begin
        o_wr_cnt++; o_wr_way = mesi_wr_way; o_wr_st = mesi_wr_state; o_wr_idx = mesi_wr_idx;
        if (wc > 0 && !wbdone) o_order_bad = 1;
        mst[mesi_wr_idx[3:0]][mesi_wr_way] = mesi_wr_state;
      end
      if (bus.snp_ready) begin o_turn = s; break; end
    end
    o_wb_cnt = wc;
    bus.rsp_ready = 1'b0; bus.wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.snp_valid = 0; bus.snp_op = '0; bus.snp_addr = '0;
    bus.rsp_ready = 0; bus.wb_ready = 0;
    for (int i = 0; i < NS; i++) clear_set(i);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nchk++;
    if ({bus.snp_ready, tag_rd_en, mesi_wr_en, bus.wb_valid, bus.rsp_valid,
         err_multi_hit, err_protocol} !== 7'b1000000)
      $display("FAIL reset_ctl got %b want 1000000", {bus.snp_ready, tag_rd_en,
               mesi_wr_en, bus.wb_valid, bus.rsp_valid, err_multi_hit, err_protocol});
    else npass++;
    nchk++;
    if ({bus.wb_addr, bus.rsp_result, mesi_wr_state, mesi_wr_way, mesi_wr_idx, tag_rd_idx} !== '0)
      $display("FAIL reset_data got nonzero want 0");
    else npass++;
    rst_n = 1'b1;
  endtask

  task automatic test_read_hitm();
    clear_set(1);
    mtag[1][5] = 12'hABC; mst[1][5] = 2'd3;
    run_op(3'd1, 32'hABC00040, 0, 3, 0);
    exp_hitm++;
    nchk++;
    if (o_res !== 2'd2) $display("FAIL hitm_res got %0d want 2", o_res); else npass++;
    nchk++;
    if (o_wb_cnt != 4 || o_wb_addr !== 32'hABC00040)
      $display("FAIL hitm_wb got %0d cyc %h want 4 cyc abc00040", o_wb_cnt, o_wb_addr);
    else npass++;
    nchk++;
    if (o_wr_cnt != 1 || o_wr_way !== 3'd5 || o_wr_st !== 2'd1 || o_wr_idx !== 14'd1)
      $display("FAIL hitm_wr got n%0d w%0d s%0d want n1 w5 s1", o_wr_cnt, o_wr_way, o_wr_st);
    else npass++;
    nchk++;
    if (o_order_bad || o_unstable) $display("FAIL hitm_order got bad want ok"); else npass++;
    nchk++;
    if (o_turn != 9) $display("FAIL hitm_turn got %0d want 9", o_turn); else npass++;
    nchk++;
    if (o_rd_cnt != 1 || o_rd_cyc != 1 || o_rsp_first != 3 || o_rd_idx !== 14'd1)
      $display("FAIL hitm_lat got rd%0d@%0d rsp@%0d want rd1@1 rsp@3",
               o_rd_cnt, o_rd_cyc, o_rsp_first);
    else npass++;
  endtask

  task automatic test_rwim_e();
    clear_set(1);
    mtag[1][5] = 12'hABC; mst[1][5] = 2'd2;
    run_op(3'd4, 32'hABC00044, 2, 0, 0);
    exp_hit++;
    nchk++;
    if (o_res !== 2'd1 || o_wb_cnt != 0)
      $display("FAIL rwim_res got %0d wb%0d want 1 wb0", o_res, o_wb_cnt);
    else npass++;
    nchk++;
    if (o_wr_cnt != 1 || o_wr_way !== 3'd5 || o_wr_st !== 2'd0)
      $display("FAIL rwim_wr got n%0d w%0d s%0d want n1 w5 s0", o_wr_cnt, o_wr_way, o_wr_st);
    else npass++;
    nchk++;
    if (o_turn != 7 || o_unstable) $display("FAIL rwim_turn got %0d want 7", o_turn);
    else npass++;
  endtask

  task automatic test_inval_e();
    clear_set(1);
    mtag[1][5] = 12'hABC; mst[1][5] = 2'd2;
    run_op(3'd3, 32'hABC00048, 0, 0, 0);
    exp_nohit++;
    nchk++;
    if (o_res !== 2'd0 || o_perr != 1)
      $display("FAIL inv_res got %0d perr%0d want 0 perr1", o_res, o_perr);
    else npass++;
    nchk++;
    if (o_wr_cnt != 1 || o_wr_st !== 2'd0 || mst[1][5] !== 2'd0)
      $display("FAIL inv_wr got n%0d s%0d want n1 s0", o_wr_cnt, o_wr_st);
    else npass++;
  endtask

  task automatic test_multi_hit();
    clear_set(2);
    mtag[2][2] = 12'h123; mst[2][2] = 2'd2;
    mtag[2][6] = 12'h123; mst[2][6] = 2'd3;
    run_op(3'd1, 32'h12300080, 0, 0, 0);
    exp_hit++;
    nchk++;
    if (o_multi != 1 || o_res !== 2'd1)
      $display("FAIL multi_res got m%0d r%0d want m1 r1", o_multi, o_res);
    else npass++;
    nchk++;
    if (o_wr_cnt != 1 || o_wr_way !== 3'd2 || o_wr_st !== 2'd1 || o_wb_cnt != 0)
      $display("FAIL multi_wr got n%0d w%0d s%0d want n1 w2 s1", o_wr_cnt, o_wr_way, o_wr_st);
    else npass++;
  endtask

  task automatic test_illegal();
    run_op(3'd7, 32'h12300080, 0, 0, 0);
    exp_nohit++;
    nchk++;
    if (o_res !== 2'd0 || o_perr != 1 || o_wr_cnt != 0)
      $display("FAIL illegal got r%0d p%0d w%0d want r0 p1 w0", o_res, o_perr, o_wr_cnt);
    else npass++;
    nchk++;
    if (o_turn != 4 || !o_acc_ready) $display("FAIL illegal_turn got %0d want 4", o_turn);
    else npass++;
  endtask

  task automatic test_reset_in_wb();
    int nwr = 0, nwb = 0;
    clear_set(3);
    mtag[3][0] = 12'h777; mst[3][0] = 2'd3;
    run_op(3'd1, 32'h777000C0, 0, 50, 2);
    nchk++;
    if ({o_rst_wbv, o_rst_rdy, o_rst_rsp} !== 3'b010)
      $display("FAIL rstwb_out got %b want 010", {o_rst_wbv, o_rst_rdy, o_rst_rsp});
    else npass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mesi_wr_en) nwr++;
      if (bus.wb_valid) nwb++;
    end
    nchk++;
    if (nwr != 0 || nwb != 0 || o_wr_cnt != 0 || mst[3][0] !== 2'd3)
      $display("FAIL rstwb_nowr got wr%0d wb%0d st%0d want 0 0 3", nwr + o_wr_cnt, nwb, mst[3][0]);
    else npass++;
    exp_hit = 0; exp_hitm = 0; exp_nohit = 0;
`ifdef SNOOP_STATS_EN
    nchk++;
    if ({stat_hit, stat_hitm, stat_nohit} !== '0)
      $display("FAIL stat_clear got %0d %0d %0d want 0 0 0", stat_hit, stat_hitm, stat_nohit);
    else npass++;
`endif
    mst[3][0] = 2'd1;
    run_op(3'd1, 32'h777000C4, 0, 0, 0);
    exp_hit++;
    nchk++;
    if (o_res !== 2'd1 || o_wr_cnt != 0 || o_turn != 4)
      $display("FAIL rstwb_after got r%0d w%0d t%0d want r1 w0 t4", o_res, o_wr_cnt, o_turn);
    else npass++;
`ifdef SNOOP_STATS_EN
    nchk++;
    if (stat_hit !== 32'd1 || stat_hitm !== 32'd0 || stat_nohit !== 32'd0)
      $display("FAIL stat_post got %0d %0d %0d want 1 0 0", stat_hit, stat_hitm, stat_nohit);
    else npass++;
`endif
  endtask

  task automatic test_random();
    logic [TAG_W-1:0] pool [4];
    pool[0] = 12'h5A0; pool[1] = 12'h5A1; pool[2] = 12'h5A2; pool[3] = 12'h5A3;
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < WAYS; w++) begin
        mtag[i][w] = pool[$urandom_range(0, 3)];
        mst[i][w]  = 2'($urandom_range(0, 3));
      end
    for (int n = 0; n < 60; n++) begin
      exp_t e;
      int idx, rs, ws, r;
      logic [2:0] op;
      logic [31:0] a;
      bit bad;
      idx = $urandom_range(0, 7);
      mtag[idx][$urandom_range(0, 7)] = pool[$urandom_range(0, 3)];
      mst[idx][$urandom_range(0, 7)]  = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      op = (r < 3) ? 3'd1 : (r < 5) ? 3'd4 : (r < 6) ? 3'd2 :
           (r < 8) ? 3'd3 : 3'($urandom_range(0, 7));
      a = {pool[$urandom_range(0, 3)], 14'(idx), 6'($urandom_range(0, 63))};
      rs = $urandom_range(0, 2);
      ws = $urandom_range(0, 2);
      e = predict(op, a);
      run_op(op, a, rs, ws, 0);
      case (e.res)
        2'd1: exp_hit++;
        2'd2: exp_hitm++;
        default: exp_nohit++;
      endcase
      nchk++;
      if (o_res !== e.res || o_hs != 1)
        $display("FAIL rnd_res op%0d a%h got %0d want %0d", op, a, o_res, e.res);
      else npass++;
      nchk++;
      if (o_turn != exp_turn(e, rs, ws))
        $display("FAIL rnd_turn op%0d got %0d want %0d", op, o_turn, exp_turn(e, rs, ws));
      else npass++;
      bad = (o_wr_cnt != (e.wr ? 1 : 0));
      if (e.wr) bad |= (int'(o_wr_way) != e.way) || (o_wr_st !== e.nst) ||
                       (o_wr_idx !== 14'(idx)) || (mst[idx][e.way] !== e.nst);
      nchk++;
      if (bad) $display("FAIL rnd_wr op%0d got n%0d w%0d s%0d want n%0d w%0d s%0d",
                        op, o_wr_cnt, o_wr_way, o_wr_st, e.wr, e.way, e.nst);
      else npass++;
      nchk++;
      if (o_wb_cnt != ((e.res == 2'd2) ? ws + 1 : 0) ||
          (e.res == 2'd2 && o_wb_addr !== {a[31:6], 6'd0}))
        $display("FAIL rnd_wb op%0d got %0d cyc %h want addr %h", op, o_wb_cnt, o_wb_addr,
                 {a[31:6], 6'd0});
      else npass++;
      nchk++;
      if (o_multi != (e.multi ? 1 : 0) || o_perr != (e.perr ? 1 : 0))
        $display("FAIL rnd_err op%0d got m%0d p%0d want m%0d p%0d",
                 op, o_multi, o_perr, e.multi, e.perr);
      else npass++;
      nchk++;
      if (o_rsp_first != 3 || o_rd_cyc != 1 || o_rd_cnt != 1 ||
          o_rd_idx !== 14'(idx) || o_unstable || o_order_bad || !o_acc_ready)
        $display("FAIL rnd_seq op%0d got rsp@%0d rd@%0d want rsp@3 rd@1", op, o_rsp_first, o_rd_cyc);
      else npass++;
    end
`ifdef SNOOP_STATS_EN
    nchk++;
    if (stat_hit !== 32'(exp_hit) || stat_hitm !== 32'(exp_hitm) || stat_nohit !== 32'(exp_nohit))
      $display("FAIL stat_rnd got %0d %0d %0d want %0d %0d %0d",
               stat_hit, stat_hitm, stat_nohit, exp_hit, exp_hitm, exp_nohit);
    else npass++;
`endif
  endtask

  initial begin
    test_reset();
    test_read_hitm();
    test_rwim_e();
    test_inval_e();
    test_multi_hit();
    test_illegal();
    test_reset_in_wb();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
